// File: rtl/vehicle_counter_pkg.sv
// Shared types and constants for the vehicle counter: FSM encoding, lane
// indices, counter widths and the saturating total helper.
package vehicle_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LANE_M1 = 2'd0,
    LANE_M2 = 2'd1,
    LANE_MT = 2'd2,
    LANE_S  = 2'd3
  } lane_t;

  localparam int N_LANES = 4;
  localparam int CNT_W   = 5;
  localparam int SUM_W   = 7;
  localparam logic [CNT_W-1:0] CNT_SAT = 5'd31;

  // Clamp the 7-bit lane sum to the 5-bit output range.
  function automatic logic [CNT_W-1:0] sat_total(input logic [SUM_W-1:0] sum);
    return (sum > SUM_W'(CNT_SAT)) ? CNT_SAT : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sensor_sync_edge.sv
// One lane: 2-flop synchronizer followed by a registered rising-edge detector.
// Edges are suppressed until the pipeline has refilled after reset.
module sensor_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic edge_det
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [2:0] arm_q;

  // arm_q keeps a level held high across reset release from reading as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      arm_q    <= '0;
      edge_det <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], sensor};
      prev_q   <= sync_q[1];
      arm_q    <= {arm_q[1:0], 1'b1};
      edge_det <= sync_q[1] & ~prev_q & arm_q[2];
    end
  end

endmodule

// File: rtl/vehicle_counter.sv
// Windowed vehicle counter: per-lane saturating counters over a fixed window,
// latching a saturated total and the busiest lane at the end of each window.
module vehicle_counter
  import vehicle_counter_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] sensor,
  output logic [4:0] NO_of_vehical,
  output logic       count_valid,
  output logic [1:0] lane_max,
  output state_t     state_dbg
);

  localparam logic [15:0] TIMER_LAST = 16'(WINDOW_CYCLES - 1);

  state_t                            state_q, state_d;
  logic [N_LANES-1:0]                edge_det;
  logic [N_LANES-1:0][CNT_W-1:0]     lane_cnt;
  logic [15:0]                       timer_q;
  logic [SUM_W-1:0]                  sum;
  logic [1:0]                        max_idx;
  logic [CNT_W-1:0]                  max_val;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    sensor_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .sensor   (sensor[gi]),
      .edge_det (edge_det[gi])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_COUNT;
      ST_COUNT: begin
        if (!en)                         state_d = ST_IDLE;
        else if (timer_q == TIMER_LAST)  state_d = ST_LATCH;
      end
      ST_LATCH: state_d = en ? ST_COUNT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Total and busiest lane; strict '>' keeps the lowest index on ties.
  always_comb begin
    sum     = '0;
    max_idx = LANE_M1;
    max_val = lane_cnt[LANE_M1];
    for (int i = 0; i < N_LANES; i++) sum = sum + SUM_W'(lane_cnt[i]);
    for (int i = 1; i < N_LANES; i++) begin
      if (lane_cnt[i] > max_val) begin
        max_val = lane_cnt[i];
        max_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q  <= '0;
      lane_cnt <= '0;
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (!en) begin
            timer_q  <= '0;
            lane_cnt <= '0;
          end else begin
            timer_q <= timer_q + 16'd1;
            for (int i = 0; i < N_LANES; i++)
              if (edge_det[i] && lane_cnt[i] != CNT_SAT) lane_cnt[i] <= lane_cnt[i] + 1'b1;
          end
        end
        // Edges arriving during LATCH open the next window.
        ST_LATCH: begin
          timer_q <= '0;
          for (int i = 0; i < N_LANES; i++) lane_cnt[i] <= CNT_W'(edge_det[i]);
        end
        default: begin
          timer_q  <= '0;
          lane_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      NO_of_vehical <= '0;
      lane_max      <= '0;
      count_valid   <= 1'b0;
    end else begin
      count_valid <= (state_q == ST_LATCH);
      if (state_q == ST_LATCH) begin
        NO_of_vehical <= sat_total(sum);
        lane_max      <= max_idx;
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_vehicle_counter.sv
// Directed bench for vehicle_counter: reset, windows, saturation, boundary,
// abort, tie and mid-window reset, with a queue of expected window results.
module tb_vehicle_counter;
  import vehicle_counter_pkg::*;

  localparam int W      = 16;
  localparam int W_SAT  = 100;
  localparam int PERIOD = W + 1;
  localparam logic [3:0] B_M1 = 4'b0001, B_M2 = 4'b0010, B_MT = 4'b0100, B_S = 4'b1000;

  logic       clk = 1'b0, rst = 1'b0, en = 1'b0, en_sat = 1'b0;
  logic [3:0] sensor = '0, sensor_sat = '0;
  logic [4:0] no_veh, no_sat;
  logic       cv, cv_sat;
  logic [1:0] lm, lm_sat;
  state_t     st, st_sat;

  int n_checks = 0, n_fail = 0, cyc = 0, last_cyc = 0, viol = 0;
  logic [6:0] exp_q[$];  // {lane_max, NO_of_vehical}

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vehicle_counter #(.WINDOW_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .en(en), .sensor(sensor),
    .NO_of_vehical(no_veh), .count_valid(cv), .lane_max(lm), .state_dbg(st)
  );

  vehicle_counter #(.WINDOW_CYCLES(W_SAT)) dut_sat (
    .clk(clk), .rst(rst), .en(en_sat), .sensor(sensor_sat),
    .NO_of_vehical(no_sat), .count_valid(cv_sat), .lane_max(lm_sat), .state_dbg(st_sat)
  );

  // outputs may only move together with a single-cycle count_valid
  logic [4:0] prev_no = '0;
  logic [1:0] prev_lm = '0;
  logic       prev_cv = 1'b0;
  always @(negedge clk) begin
    if (rst && !cv && (no_veh !== prev_no || lm !== prev_lm)) viol <= viol + 1;
    if (cv && prev_cv) viol <= viol + 1;
    prev_no <= no_veh;
    prev_lm <= lm;
    prev_cv <= cv;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic pulse(input logic [3:0] lanes, input bit sat = 1'b0);
    if (sat) sensor_sat = lanes; else sensor = lanes;
    @(negedge clk);
    if (sat) sensor_sat = '0; else sensor = '0;
    @(negedge clk);
  endtask

  task automatic expect_window(input logic [4:0] no, input logic [1:0] lane);
    exp_q.push_back({lane, no});
  endtask

  task automatic quiet(input string tag, input int n, input logic [4:0] no, input logic [1:0] lane);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (cv) seen++;
    end
    check({tag, "_cv"}, seen, 0);
    check({tag, "_no"}, no_veh, no);
    check({tag, "_lm"}, lm, lane);
  endtask

  task automatic take_window(input string tag, input int gap);
    int waited = 0;
    logic [6:0] e = '0;
    do begin
      @(negedge clk);
      waited++;
    end while (!cv && waited < 3 * PERIOD);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (!cv) check({tag, "_timeout"}, cv, 1);
    else begin
      check({tag, "_no"}, no_veh, e[4:0]);
      check({tag, "_lm"}, lm, e[6:5]);
      if (gap > 0) check({tag, "_gap"}, cyc - last_cyc, gap);
      last_cyc = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with toggling sensors
    for (int i = 0; i < 6; i++) begin
      sensor = (i % 2 == 0) ? 4'b0101 : 4'b1010;
      @(negedge clk);
    end
    check("rst_no", no_veh, 0);
    check("rst_lm", lm, 0);
    check("rst_cv", cv, 0);
    check("rst_state", st, ST_IDLE);

    // release with all sensors held high: must not count
    sensor = 4'hF;
    en     = 1'b1;
    rst    = 1'b1;
    quiet("rst_release", 16, 0, 0);
    expect_window(0, 0);
    take_window("held_high", 0);
    sensor = '0;

    expect_window(5, LANE_M1);
    @(negedge clk);
    pulse(B_M1 | B_S); pulse(B_M1 | B_S); pulse(B_M1);
    take_window("basic", PERIOD);

    expect_window(4, LANE_S);
    @(negedge clk);
    pulse(B_M1 | B_S); pulse(B_S); pulse(B_S);
    take_window("lane_s", PERIOD);

    expect_window(4, LANE_MT);
    @(negedge clk);
    pulse(B_MT | B_S); pulse(B_MT | B_S);
    take_window("tie", PERIOD);

    // MT edge lands exactly on the LATCH cycle of this window
    expect_window(0, 0);
    repeat (13) @(negedge clk);
    sensor = B_MT;
    @(negedge clk);
    sensor = '0;
    take_window("boundary_cur", PERIOD);
    expect_window(1, LANE_MT);
    take_window("boundary_next", PERIOD);

    // abort at timer=8 after 4 counts
    pulse(B_M1 | B_M2); pulse(B_M1 | B_M2);
    repeat (4) @(negedge clk);
    check("pre_abort_state", st, ST_COUNT);
    en = 1'b0;
    quiet("abort", 20, 1, LANE_MT);
    check("abort_state", st, ST_IDLE);
    en = 1'b1;
    expect_window(1, LANE_S);
    repeat (2) @(negedge clk);
    pulse(B_S);
    take_window("restart", 0);

    // asynchronous reset mid-window
    pulse(B_M1); pulse(B_M1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_no", no_veh, 0);
    check("async_rst_lm", lm, 0);
    check("async_rst_state", st, ST_IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    quiet("post_rst", 16, 0, 0);
    expect_window(0, 0);
    take_window("post_rst_window", 0);
    en = 1'b0;

    // 40 M2 pulses in a 100-cycle window: lane counter must hold at 31
    en_sat = 1'b1;
    repeat (2) @(negedge clk);
    repeat (40) pulse(B_M2, 1'b1);
    begin
      int waited = 0;
      while (!cv_sat && waited < 2 * W_SAT) begin
        @(negedge clk);
        waited++;
      end
    end
    check("sat_cv", cv_sat, 1);
    check("sat_no", no_sat, 31);
    check("sat_lm", lm_sat, LANE_M2);
    en_sat = 1'b0;

    // final report
    check("outputs_stable_between_pulses", viol, 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
